bus_arbiter: RTL and testbench

// Decides, per phi cycle, whether the VIC takes the phi2 half-cycle from the CPU (badline c-accesses,

---
 rtl/bus_arbiter.sv | 89 ++++++++
 tb/tb_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Phi-cycle bus arbiter: decides when the VIC steals the phi2 half-cycle from the CPU,
// raising the BA warning ahead of each steal and gating AEC once that warning is long enough.
module bus_arbiter #(
    parameter int CYCLES_PER_LINE = 63,
    parameter int CHR_START       = 15,
    parameter int CHR_LEN         = 40,
    parameter int SPR0_CYCLE      = 58,
    parameter int NUM_SPRITES     = 8,
    parameter int BA_LEAD         = 3
) (
    input  logic                   clk_dot4x,
    input  logic                   rst_n,
    input  logic                   phi_phase_start_0,
    input  logic                   phi_phase_start_1,
    input  logic [6:0]             cycle_num,
    input  logic                   badline,
    input  logic [NUM_SPRITES-1:0] sprite_dma,
    output logic                   ba,
    output logic                   aec,
    output logic                   steal,
    output logic [1:0]             ba_cnt
);

    localparam logic [1:0] LEAD_SAT = 2'(BA_LEAD);

    logic need_now;
    logic need_ahead;
    logic ba_next;

    function automatic logic need(input logic [6:0] c,
                                  input logic bl,
                                  input logic [NUM_SPRITES-1:0] dma);
        logic hit;
        int   ci;
        int   s0;
        int   s1;
        ci  = int'(c);
        hit = bl && (ci >= CHR_START) && (ci < CHR_START + CHR_LEN);
        // Sprite slots wrap past the end of the line, so late sprites steal early cycles.
        for (int n = 0; n < NUM_SPRITES; n++) begin
            s0 = (SPR0_CYCLE + 2 * n) % CYCLES_PER_LINE;
            s1 = (SPR0_CYCLE + 2 * n + 1) % CYCLES_PER_LINE;
            if (dma[n] && (ci == s0 || ci == s1)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [6:0] wrap_add(input logic [6:0] c, input int k);
        int t;
        t = int'(c) + k;
        if (t >= CYCLES_PER_LINE) begin
            t = t - CYCLES_PER_LINE;
        end
        return 7'(t);
    endfunction

    always_comb begin
        need_now   = need(cycle_num, badline, sprite_dma);
        need_ahead = 1'b0;
        for (int k = 1; k <= BA_LEAD; k++) begin
            need_ahead = need_ahead | need(wrap_add(cycle_num, k), badline, sprite_dma);
        end
        ba_next = !(need_now || need_ahead);
    end

    // phi1 always belongs to the VIC; phi2 is taken only once BA has been low long enough.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            ba     <= 1'b1;
            aec    <= 1'b1;
            steal  <= 1'b0;
            ba_cnt <= 2'd0;
        end else if (phi_phase_start_0) begin
            ba    <= ba_next;
            steal <= need_now;
            aec   <= 1'b0;
            if (!ba_next) begin
                ba_cnt <= (ba_cnt >= LEAD_SAT) ? LEAD_SAT : ba_cnt + 2'd1;
            end else begin
                ba_cnt <= 2'd0;
            end
        end else if (phi_phase_start_1) begin
            aec <= !(steal && (ba_cnt >= LEAD_SAT));
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: walks phi cycles through raster lines and checks
// BA / AEC / steal / ba_cnt against hand-derived per-cycle expectations.
module tb_bus_arbiter;

    logic       clk_dot4x = 1'b0;
    logic       rst_n;
    logic       phi_phase_start_0;
    logic       phi_phase_start_1;
    logic [6:0] cycle_num;
    logic       badline;
    logic [7:0] sprite_dma;
    logic       ba;
    logic       aec;
    logic       steal;
    logic [1:0] ba_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic       s_ba;
    logic       s_steal;
    logic       s_aec1;
    logic       s_aec2;
    logic [1:0] s_cnt;

    always #5 clk_dot4x = ~clk_dot4x;

    bus_arbiter dut (
        .clk_dot4x         (clk_dot4x),
        .rst_n             (rst_n),
        .phi_phase_start_0 (phi_phase_start_0),
        .phi_phase_start_1 (phi_phase_start_1),
        .cycle_num         (cycle_num),
        .badline           (badline),
        .sprite_dma        (sprite_dma),
        .ba                (ba),
        .aec               (aec),
        .steal             (steal),
        .ba_cnt            (ba_cnt)
    );

    // One phi cycle = four clocks: phi1 strobe, idle, phi2 strobe, idle.
    task automatic run_cycle(input int c, input logic both = 1'b0);
        @(negedge clk_dot4x);
        cycle_num         = 7'(c);
        phi_phase_start_0 = 1'b1;
        phi_phase_start_1 = both;
        @(negedge clk_dot4x);
        phi_phase_start_0 = 1'b0;
        phi_phase_start_1 = 1'b0;
        s_ba    = ba;
        s_steal = steal;
        s_cnt   = ba_cnt;
        s_aec1  = aec;
        @(negedge clk_dot4x);
        if (!both) phi_phase_start_1 = 1'b1;
        @(negedge clk_dot4x);
        phi_phase_start_1 = 1'b0;
        s_aec2 = aec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        phi_phase_start_0 = 1'b0;
        phi_phase_start_1 = 1'b0;
        cycle_num  = 7'd0;
        badline    = 1'b0;
        sprite_dma = 8'h00;
        repeat (3) @(negedge clk_dot4x);
        vectors++;
        if ({ba, aec, steal, ba_cnt} !== 5'b11000) begin
            miscompares++;
            $display("[TB] FAIL reset_state got ba=%b aec=%b steal=%b cnt=%0d want 1 1 0 0", ba, aec, steal, ba_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_dot4x);
    endtask

    task automatic test_badline();
        logic e_ba;
        logic e_steal;
        badline    = 1'b1;
        sprite_dma = 8'h00;
        for (int c = 0; c < 63; c++) begin
            run_cycle(c);
            e_ba    = !(c >= 12 && c <= 54);
            e_steal = (c >= 15 && c <= 54);
            vectors += 4;
            if (s_ba !== e_ba) begin
                miscompares++;
                $display("[TB] FAIL badline_ba c=%0d got %b want %b", c, s_ba, e_ba);
            end
            if (s_steal !== e_steal) begin
                miscompares++;
                $display("[TB] FAIL badline_steal c=%0d got %b want %b", c, s_steal, e_steal);
            end
            if (s_aec1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL badline_aec_phi1 c=%0d got %b want 0", c, s_aec1);
            end
            if (s_aec2 !== !e_steal) begin
                miscompares++;
                $display("[TB] FAIL badline_aec_phi2 c=%0d got %b want %b", c, s_aec2, !e_steal);
            end
            if (c == 12 || c == 14) begin
                vectors++;
                if (s_cnt !== ((c == 12) ? 2'd1 : 2'd3)) begin
                    miscompares++;
                    $display("[TB] FAIL badline_cnt c=%0d got %0d want %0d", c, s_cnt, (c == 12) ? 1 : 3);
                end
            end
        end
    endtask

    task automatic test_sprite(input logic [7:0] dma, input int ba_lo, input int st_lo);
        logic e_ba;
        logic e_steal;
        badline    = 1'b0;
        sprite_dma = dma;
        for (int c = 0; c < 63; c++) begin
            run_cycle(c);
            e_ba    = !(c >= ba_lo && c <= st_lo + 1);
            e_steal = (c == st_lo || c == st_lo + 1);
            vectors += 3;
            if (s_ba !== e_ba) begin
                miscompares++;
                $display("[TB] FAIL sprite%02h_ba c=%0d got %b want %b", dma, c, s_ba, e_ba);
            end
            if (s_steal !== e_steal) begin
                miscompares++;
                $display("[TB] FAIL sprite%02h_steal c=%0d got %b want %b", dma, c, s_steal, e_steal);
            end
            if (s_aec2 !== !e_steal) begin
                miscompares++;
                $display("[TB] FAIL sprite%02h_aec_phi2 c=%0d got %b want %b", dma, c, s_aec2, !e_steal);
            end
        end
    endtask

    task automatic test_late_dma();
        logic e_ba;
        badline    = 1'b0;
        sprite_dma = 8'h00;
        for (int c = 57; c < 60; c++) run_cycle(c);
        sprite_dma = 8'h01;
        for (int i = 0; i < 63; i++) begin
            run_cycle((60 + i) % 63);
            e_ba = !(((60 + i) % 63) >= 55 && ((60 + i) % 63) <= 59);
            vectors++;
            if (s_ba !== e_ba) begin
                miscompares++;
                $display("[TB] FAIL late_dma_ba c=%0d got %b want %b", (60 + i) % 63, s_ba, e_ba);
            end
            if (i == 0 || (60 + i) % 63 == 55) begin
                vectors++;
                if (s_cnt !== ((i == 0) ? 2'd0 : 2'd1)) begin
                    miscompares++;
                    $display("[TB] FAIL late_dma_cnt c=%0d got %0d want %0d", (60 + i) % 63, s_cnt, (i == 0) ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_late_badline();
        logic       e_ba;
        logic       e_aec2;
        logic [1:0] e_cnt;
        badline    = 1'b0;
        sprite_dma = 8'h00;
        for (int c = 0; c < 20; c++) run_cycle(c);
        badline = 1'b1;
        for (int c = 20; c < 63; c++) begin
            run_cycle(c);
            e_ba   = (c > 54);
            e_aec2 = !(c >= 22 && c <= 54);
            e_cnt  = (c == 20) ? 2'd1 : (c == 21) ? 2'd2 : (c <= 54) ? 2'd3 : 2'd0;
            vectors += 4;
            if (s_ba !== e_ba) begin
                miscompares++;
                $display("[TB] FAIL late_badline_ba c=%0d got %b want %b", c, s_ba, e_ba);
            end
            if (s_steal !== (c <= 54)) begin
                miscompares++;
                $display("[TB] FAIL late_badline_steal c=%0d got %b want %b", c, s_steal, c <= 54);
            end
            if (s_aec2 !== e_aec2) begin
                miscompares++;
                $display("[TB] FAIL late_badline_aec_phi2 c=%0d got %b want %b", c, s_aec2, e_aec2);
            end
            if (s_cnt !== e_cnt) begin
                miscompares++;
                $display("[TB] FAIL late_badline_cnt c=%0d got %0d want %0d", c, s_cnt, e_cnt);
            end
        end
    endtask

    task automatic test_both_strobes();
        badline    = 1'b1;
        sprite_dma = 8'h00;
        for (int c = 0; c < 12; c++) run_cycle(c);
        run_cycle(12, 1'b1);
        vectors += 2;
        if (s_aec1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL both_strobes_aec got %b want 0", s_aec1);
        end
        if ({s_ba, s_cnt} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL both_strobes_ba_cnt got ba=%b cnt=%0d want 0 1", s_ba, s_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 13; c <= 30; c++) run_cycle(c);
        vectors++;
        if ({s_ba, s_aec2} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_steal got ba=%b aec=%b want 0 0", s_ba, s_aec2);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ba, aec, steal, ba_cnt} !== 5'b11000) begin
            miscompares++;
            $display("[TB] FAIL async_reset got ba=%b aec=%b steal=%b cnt=%0d want 1 1 0 0", ba, aec, steal, ba_cnt);
        end
        @(negedge clk_dot4x);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_dot4x);
        vectors++;
        if ({ba, aec, steal, ba_cnt} !== 5'b11000) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got ba=%b aec=%b steal=%b cnt=%0d want 1 1 0 0", ba, aec, steal, ba_cnt);
        end
        run_cycle(31);
        vectors++;
        if ({s_ba, s_steal, s_cnt, s_aec2} !== 5'b01011) begin
            miscompares++;
            $display("[TB] FAIL post_reset_cycle got ba=%b steal=%b cnt=%0d aec=%b want 0 1 1 1", s_ba, s_steal, s_cnt, s_aec2);
        end
    endtask

    task automatic test_back_to_back();
        badline    = 1'b1;
        sprite_dma = 8'hFF;
        for (int c = 32; c < 63; c++) run_cycle(c);
        for (int i = 0; i < 75; i++) begin
            run_cycle(i % 63);
            vectors++;
            if (s_ba !== ((i % 63) == 11)) begin
                miscompares++;
                $display("[TB] FAIL b2b_ba i=%0d got %b want %b", i, s_ba, (i % 63) == 11);
            end
            if (i >= 14 && i != 74) begin
                vectors++;
                if (s_cnt !== 2'd3) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_cnt i=%0d got %0d want 3", i, s_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_badline();
        test_sprite(8'h01, 55, 58);
        test_sprite(8'h80, 6, 9);
        test_late_dma();
        test_late_badline();
        test_both_strobes();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
